// File: rtl/md_defs_pkg.sv
// Shared definitions for the multiply/divide sequencer: op encoding,
// FSM state encoding and small op-class helpers.
package md_defs;

  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MTHI  = 4'd5;
  localparam logic [3:0] MD_MTLO  = 4'd6;
  localparam logic [3:0] MD_MFHI  = 4'd7;
  localparam logic [3:0] MD_MFLO  = 4'd8;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } md_state_e;

  // Ops that occupy the unit for a multi-cycle countdown.
  function automatic logic is_muldiv(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_mul(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

endpackage

// File: rtl/muldiv_calc.sv
// Combinational 32x32 multiply / divide datapath producing the 64-bit
// {hi, lo} result and a divide-by-zero flag for the sequencer.
module muldiv_calc
  import md_defs::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        divZero
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        signed_div;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] divisor;
  logic [31:0] quo;
  logic [31:0] rem;

  always_comb begin
    // Sign-extended operands give the signed product modulo 2^64.
    prod_s     = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    prod_u     = {32'b0, a} * {32'b0, b};

    // Signed divide on magnitudes: avoids the 0x80000000 / -1 overflow and
    // gives truncation toward zero with the remainder following the dividend.
    signed_div = (op == MD_DIV);
    mag_a      = (signed_div && a[31]) ? -a : a;
    mag_b      = (signed_div && b[31]) ? -b : b;
    divisor    = (mag_b == 32'd0) ? 32'd1 : mag_b;
    quo        = mag_a / divisor;
    rem        = mag_a % divisor;
    if (signed_div && (a[31] ^ b[31])) quo = -quo;
    if (signed_div && a[31])           rem = -rem;

    divZero    = ((op == MD_DIV) || (op == MD_DIVU)) && (b == 32'd0);

    hi = 32'd0;
    lo = 32'd0;
    case (op)
      MD_MULT:          {hi, lo} = prod_s;
      MD_MULTU:         {hi, lo} = prod_u;
      MD_DIV, MD_DIVU:  begin hi = rem; lo = quo; end
      default:          begin hi = 32'd0; lo = 32'd0; end
    endcase
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multiply/divide sequencer: owns HI/LO, models fixed mult/div latency
// with a countdown and raises the D-stage stall while an op is in flight.
module muldiv_sequencer
  import md_defs::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  E_mdOp,
  input  logic [31:0] E_rsData,
  input  logic [31:0] E_rtData,
  input  logic        req,
  input  logic        D_isMd,
  output logic        busy,
  output logic        start,
  output logic        mdStall,
  output logic [31:0] hiloRdata
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  md_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        hi_q, hi_d;
  logic [31:0]        lo_q, lo_d;
  logic [31:0]        pend_hi_q, pend_hi_d;
  logic [31:0]        pend_lo_q, pend_lo_d;
  logic               pend_wr_q, pend_wr_d;

  logic [31:0]        calc_hi;
  logic [31:0]        calc_lo;
  logic               calc_div_zero;

  muldiv_calc u_calc (
    .op      (E_mdOp),
    .a       (E_rsData),
    .b       (E_rtData),
    .hi      (calc_hi),
    .lo      (calc_lo),
    .divZero (calc_div_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_wr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;
    start     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!req) begin
          if (is_muldiv(E_mdOp)) begin
            start     = 1'b1;
            pend_hi_d = calc_hi;
            pend_lo_d = calc_lo;
            pend_wr_d = !calc_div_zero;
            cnt_d     = is_mul(E_mdOp) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
            state_d   = S_BUSY;
          end else if (E_mdOp == MD_MTHI) begin
            hi_d = E_rsData;
          end else if (E_mdOp == MD_MTLO) begin
            lo_d = E_rsData;
          end
        end
      end
      S_BUSY: begin
        // Everything arriving from E is ignored here; req does not cancel.
        if (cnt_q == CNT_W'(1)) begin
          if (pend_wr_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign busy    = (state_q == S_BUSY);
  assign mdStall = D_isMd & (busy | start);

  always_comb begin
    hiloRdata = 32'd0;
    if (E_mdOp == MD_MFHI)      hiloRdata = hi_q;
    else if (E_mdOp == MD_MFLO) hiloRdata = lo_q;
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: a vector table for single ops plus
// hand sequences for ignored ops while busy and reset in mid-divide.
module tb_muldiv_sequencer;
  import md_defs::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  E_mdOp;
  logic [31:0] E_rsData;
  logic [31:0] E_rtData;
  logic        req;
  logic        D_isMd;
  logic        busy;
  logic        start;
  logic        mdStall;
  logic [31:0] hiloRdata;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        req;
    int          cycles;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[14];

  muldiv_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .E_mdOp    (E_mdOp),
    .E_rsData  (E_rsData),
    .E_rtData  (E_rtData),
    .req       (req),
    .D_isMd    (D_isMd),
    .busy      (busy),
    .start     (start),
    .mdStall   (mdStall),
    .hiloRdata (hiloRdata)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // driver: present one op for a single cycle, then return the bus to NONE
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic r, input logic exp_start);
    @(negedge clk);
    E_mdOp = op; E_rsData = a; E_rtData = b; req = r;
    #1;
    check("start", {31'b0, start}, {31'b0, exp_start});
    check("stall_at_start", {31'b0, mdStall}, {31'b0, D_isMd & exp_start});
    check("busy_at_start", {31'b0, busy}, 32'd0);
    @(posedge clk);
    #1;
    E_mdOp = MD_NONE; req = 1'b0;
  endtask

  // counts busy cycles (bounded), checking stall/start each busy cycle
  task automatic wait_idle(output int n);
    n = 0;
    @(negedge clk);
    while (busy && n < 40) begin
      check("stall_busy", {31'b0, mdStall}, {31'b0, D_isMd});
      check("start_busy", {31'b0, start}, 32'd0);
      n++;
      @(negedge clk);
    end
    check("stall_idle", {31'b0, mdStall}, 32'd0);
  endtask

  task automatic read_hilo(output logic [31:0] h, output logic [31:0] l);
    E_mdOp = MD_NONE; #1;
    check("rdata_none", hiloRdata, 32'd0);
    E_mdOp = MD_MFHI; #1; h = hiloRdata;
    E_mdOp = MD_MFLO; #1; l = hiloRdata;
    E_mdOp = MD_NONE; #1;
  endtask

  // scoreboard: compare HI then LO against the expected queue
  task automatic score(input string name, input logic [31:0] h, input logic [31:0] l);
    logic [31:0] e;
    if (exp_q.size() < 2) begin
      n_checks++; n_fail++;
      $display("FAIL %s: expected queue empty", name);
    end else begin
      e = exp_q.pop_front(); check({name, "_hi"}, h, e);
      e = exp_q.pop_front(); check({name, "_lo"}, l, e);
    end
  endtask

  initial begin
    int          n;
    logic [31:0] h, l;
    logic        es;

    vecs[0]  = '{MD_MULT,  32'hFFFFFFFF, 32'h00000002, 1'b0, 5,  32'hFFFFFFFF, 32'hFFFFFFFE};
    vecs[1]  = '{MD_MULTU, 32'hFFFFFFFF, 32'h00000002, 1'b0, 5,  32'h00000001, 32'hFFFFFFFE};
    vecs[2]  = '{MD_DIV,   32'hFFFFFFF9, 32'h00000002, 1'b0, 10, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{MD_MTHI,  32'h00000011, 32'h0,        1'b0, 0,  32'h00000011, 32'hFFFFFFFD};
    vecs[4]  = '{MD_MTLO,  32'h00000022, 32'h0,        1'b0, 0,  32'h00000011, 32'h00000022};
    vecs[5]  = '{MD_DIVU,  32'h00000005, 32'h00000000, 1'b0, 10, 32'h00000011, 32'h00000022};
    vecs[6]  = '{MD_MULT,  32'h00000003, 32'h00000004, 1'b1, 0,  32'h00000011, 32'h00000022};
    vecs[7]  = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 1'b0, 10, 32'h00000000, 32'h80000000};
    vecs[8]  = '{MD_DIVU,  32'hFFFFFFFF, 32'h00000010, 1'b0, 10, 32'h0000000F, 32'h0FFFFFFF};
    vecs[9]  = '{MD_DIV,   32'h00000007, 32'hFFFFFFFE, 1'b0, 10, 32'h00000001, 32'hFFFFFFFD};
    vecs[10] = '{MD_MULT,  32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0, 5,  32'h3FFFFFFF, 32'h00000001};
    vecs[11] = '{4'd9,     32'h12345678, 32'h9ABCDEF0, 1'b0, 0,  32'h3FFFFFFF, 32'h00000001};
    vecs[12] = '{MD_MTLO,  32'h000000AB, 32'h0,        1'b1, 0,  32'h3FFFFFFF, 32'h00000001};
    vecs[13] = '{MD_MULTU, 32'h80000000, 32'h80000000, 1'b0, 5,  32'h40000000, 32'h00000000};

    reset = 1'b1; E_mdOp = MD_NONE; E_rsData = '0; E_rtData = '0; req = 1'b0; D_isMd = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset_busy", {31'b0, busy}, 32'd0);
    exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    read_hilo(h, l);
    score("reset_hilo", h, l);

    for (int i = 0; i < 14; i++) begin
      es = (vecs[i].op >= MD_MULT) && (vecs[i].op <= MD_DIVU) && !vecs[i].req;
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].req, es);
      wait_idle(n);
      check($sformatf("vec%0d_cycles", i), n, vecs[i].cycles);
      exp_q.push_back(vecs[i].hi); exp_q.push_back(vecs[i].lo);
      read_hilo(h, l);
      score($sformatf("vec%0d", i), h, l);
    end

    // MTLO, DIV and req all arrive while a MULT is in flight; none may disturb it
    issue(MD_MULT, 32'd2, 32'd3, 1'b0, 1'b1);
    n = 0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (busy) n++;
      case (k)
        2:       begin E_mdOp = MD_MTLO; E_rsData = 32'h1234; end
        3:       begin E_mdOp = MD_DIV;  E_rsData = 32'd9; E_rtData = 32'd2; end
        4:       begin E_mdOp = MD_NONE; req = 1'b1; end
        default: begin E_mdOp = MD_NONE; req = 1'b0; end
      endcase
      #1;
      check("busy_ignore_start", {31'b0, start}, 32'd0);
      check("busy_ignore_stall", {31'b0, mdStall}, 32'd1);
    end
    @(negedge clk);
    check("busy_ignore_cycles", n, 5);
    check("busy_ignore_done", {31'b0, busy}, 32'd0);
    exp_q.push_back(32'd0); exp_q.push_back(32'd6);
    read_hilo(h, l);
    score("busy_ignore", h, l);

    // reset asserted in the third busy cycle of a DIV
    issue(MD_MTHI, 32'h55, 32'd0, 1'b0, 1'b0);
    issue(MD_DIV, 32'd100, 32'd7, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    check("mid_div_busy", {31'b0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    check("reset_mid_busy", {31'b0, busy}, 32'd0);
    exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    read_hilo(h, l);
    score("reset_mid", h, l);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("post_reset_busy", {31'b0, busy}, 32'd0);
    E_mdOp = MD_MFLO; #1;
    check("post_reset_mflo", hiloRdata, 32'd0);
    E_mdOp = MD_NONE;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
